// File: rtl/cpu_bus_pkg.sv
// Shared types and default addresses for the CPU bus controller and its OAM DMA engine.
package cpu_bus_pkg;

    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} dma_state_t;

    localparam logic [15:0] DMA_PAGE_ADDR = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/cpu_bus_ctrl_if.sv
// Core-side and system-bus-side signals of the CPU bus controller, plus interrupt sources.
interface cpu_bus_ctrl_if #(
    parameter int IRQ_CH = 2
);
    logic [15:0]       cpu_addr;
    logic [7:0]        cpu_dout;
    logic              cpu_rw_n;
    logic [7:0]        cpu_din;
    logic              cpu_enable;
    logic              cpu_nmi_n;
    logic              cpu_irq_n;
    logic [15:0]       bus_addr;
    logic [7:0]        bus_dout;
    logic              bus_rw_n;
    logic [7:0]        bus_din;
    logic              nmi_src;
    logic [IRQ_CH-1:0] irq_src;
    logic [IRQ_CH-1:0] irq_mask;
    logic              dma_active;

    modport master (
        output cpu_addr, cpu_dout, cpu_rw_n, bus_din, nmi_src, irq_src, irq_mask,
        input  cpu_din, cpu_enable, cpu_nmi_n, cpu_irq_n, bus_addr, bus_dout, bus_rw_n, dma_active
    );

    modport slave (
        input  cpu_addr, cpu_dout, cpu_rw_n, bus_din, nmi_src, irq_src, irq_mask,
        output cpu_din, cpu_enable, cpu_nmi_n, cpu_irq_n, bus_addr, bus_dout, bus_rw_n, dma_active
    );
endinterface

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: halts the core, optionally aligns to an odd cycle, then copies one
// page to the OAM data port as alternating READ/WRITE CPU cycles. Advances only on tick.
module oam_dma_engine #(
    parameter int          DMA_LEN = 256,
    parameter logic [15:0] WR_ADDR = cpu_bus_pkg::OAM_DATA_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_tick,
    input  logic        i_parity,
    input  logic        i_trigger,
    input  logic [7:0]  i_page,
    input  logic [7:0]  i_bus_din,
    output logic        o_active,
    output logic        o_own_addr,
    output logic [15:0] o_addr,
    output logic [7:0]  o_dout,
    output logic        o_rw_n
);
    import cpu_bus_pkg::*;

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    dma_state_t r_state;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic [7:0] r_data;
    logic       w_last;

    assign w_last = (r_idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_page  <= 8'd0;
            r_idx   <= 8'd0;
            r_data  <= 8'd0;
        end else if (i_tick) begin
            case (r_state)
                IDLE: begin
                    if (i_trigger) begin
                        r_page  <= i_page;
                        r_state <= HALT;
                    end
                end
                // An even halt cycle needs one extra cycle so reads land on even cycles.
                HALT:  r_state <= i_parity ? READ : ALIGN;
                ALIGN: r_state <= READ;
                READ: begin
                    r_data  <= i_bus_din;
                    r_state <= WRITE;
                end
                WRITE: begin
                    r_idx   <= w_last ? 8'd0 : r_idx + 8'd1;
                    r_state <= w_last ? IDLE : READ;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_active   = (r_state != IDLE);
    assign o_own_addr = (r_state == READ) || (r_state == WRITE);
    assign o_addr     = (r_state == WRITE) ? WR_ADDR : {r_page, r_idx};
    assign o_dout     = r_data;
    assign o_rw_n     = (r_state != WRITE);
endmodule

// File: rtl/cpu_bus_ctrl.sv
// CPU bus controller: CPU clock-enable divider, bus mux with write loopback, OAM DMA,
// NMI edge conditioning and IRQ level conditioning for the T65 core.
module cpu_bus_ctrl #(
    parameter int          CLK_DIV       = 12,
    parameter int          IRQ_CH        = 2,
    parameter int          DMA_LEN       = 256,
    parameter logic [15:0] DMA_PAGE_ADDR = cpu_bus_pkg::DMA_PAGE_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = cpu_bus_pkg::OAM_DATA_ADDR
) (
    input  logic          CLK,
    input  logic          RESET,
    cpu_bus_ctrl_if.slave bif
);
    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0]     r_tick_cnt;
    logic              r_parity;
    logic [7:0]        r_din_hold;
    logic [2:0]        r_nmi_sync;
    logic              r_nmi_pend;
    logic              r_nmi_n;
    logic              r_nmi_cnt;
    logic [IRQ_CH-1:0] r_irq_s1;
    logic [IRQ_CH-1:0] r_irq_s2;
    logic              r_irq_n;

    logic              w_tick;
    logic              w_cpu_enable;
    logic              w_trigger;
    logic              w_nmi_edge;
    logic              w_nmi_start;
    logic [7:0]        w_din_live;
    logic              w_dma_active;
    logic              w_dma_own;
    logic [15:0]       w_dma_addr;
    logic [7:0]        w_dma_dout;
    logic              w_dma_rw_n;

    assign w_tick       = (r_tick_cnt == CW'(CLK_DIV - 1));
    assign w_cpu_enable = w_tick & ~w_dma_active;
    assign w_trigger    = w_tick & ~bif.cpu_rw_n & (bif.cpu_addr == DMA_PAGE_ADDR);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_tick_cnt <= '0;
            r_parity   <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CW'(1);
            if (w_tick) r_parity <= ~r_parity;
        end
    end

    oam_dma_engine #(
        .DMA_LEN (DMA_LEN),
        .WR_ADDR (OAM_DATA_ADDR)
    ) u_dma (
        .clk        (CLK),
        .rst        (RESET),
        .i_tick     (w_tick),
        .i_parity   (r_parity),
        .i_trigger  (w_trigger),
        .i_page     (bif.cpu_dout),
        .i_bus_din  (bif.bus_din),
        .o_active   (w_dma_active),
        .o_own_addr (w_dma_own),
        .o_addr     (w_dma_addr),
        .o_dout     (w_dma_dout),
        .o_rw_n     (w_dma_rw_n)
    );

    assign w_din_live = bif.cpu_rw_n ? bif.bus_din : bif.cpu_dout;

    // The halted core must see a stable DI for the whole transfer.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)              r_din_hold <= 8'd0;
        else if (!w_dma_active) r_din_hold <= w_din_live;
    end

    assign w_nmi_edge  = r_nmi_sync[1] & ~r_nmi_sync[2];
    assign w_nmi_start = w_cpu_enable & r_nmi_n & r_nmi_pend;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_nmi_sync <= 3'b000;
            r_nmi_pend <= 1'b0;
            r_nmi_n    <= 1'b1;
            r_nmi_cnt  <= 1'b0;
        end else begin
            r_nmi_sync <= {r_nmi_sync[1:0], bif.nmi_src};
            // A new edge wins over the clear so a re-request is never lost.
            if (w_nmi_edge)       r_nmi_pend <= 1'b1;
            else if (w_nmi_start) r_nmi_pend <= 1'b0;
            if (w_nmi_start) begin
                r_nmi_n   <= 1'b0;
                r_nmi_cnt <= 1'b0;
            end else if (w_cpu_enable && !r_nmi_n) begin
                if (r_nmi_cnt) r_nmi_n <= 1'b1;
                r_nmi_cnt <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_irq_s1 <= '0;
            r_irq_s2 <= '0;
            r_irq_n  <= 1'b1;
        end else begin
            r_irq_s1 <= bif.irq_src;
            r_irq_s2 <= r_irq_s1;
            r_irq_n  <= ~|(r_irq_s2 & ~bif.irq_mask);
        end
    end

    assign bif.cpu_enable = w_cpu_enable;
    assign bif.dma_active = w_dma_active;
    assign bif.cpu_nmi_n  = r_nmi_n;
    assign bif.cpu_irq_n  = r_irq_n;
    assign bif.cpu_din    = w_dma_active ? r_din_hold : w_din_live;
    assign bif.bus_addr   = w_dma_own    ? w_dma_addr : bif.cpu_addr;
    assign bif.bus_rw_n   = w_dma_active ? w_dma_rw_n : bif.cpu_rw_n;
    assign bif.bus_dout   = w_dma_active ? w_dma_dout : bif.cpu_dout;
endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Bench for cpu_bus_ctrl: memory model on the system bus, scoreboard of expected OAM writes.
module tb_cpu_bus_ctrl;
    localparam int CLK_DIV = 12;
    localparam int DMA_LEN = 256;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   clk_cnt;
    int   wr_cnt = 0;
    logic wr_prev = 1'b0;
    logic [7:0] exp_q [$];
    logic [7:0] mem [0:65535];

    cpu_bus_ctrl_if #(.IRQ_CH(2)) bif ();

    cpu_bus_ctrl #(
        .CLK_DIV (CLK_DIV),
        .IRQ_CH  (2),
        .DMA_LEN (DMA_LEN)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bif   (bif)
    );

    always #5 CLK = ~CLK;

    assign bif.bus_din = mem[bif.bus_addr];

    // Posedges since reset release; a tick is the cycle where clk_cnt % CLK_DIV == CLK_DIV-1.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) clk_cnt <= 0;
        else       clk_cnt <= clk_cnt + 1;
    end

    // Advance to the next negedge and score any new write to the OAM data port.
    task automatic step();
        logic       now;
        logic [7:0] e;
        @(negedge CLK);
        now = !RESET && bif.dma_active && !bif.bus_rw_n && (bif.bus_addr == 16'h2004);
        if (now && !wr_prev) begin
            wr_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL dma_write_unexpected: got write of %h, expected no write", bif.bus_dout);
            end else begin
                e = exp_q.pop_front();
                if (bif.bus_dout !== e) begin
                    miscompares++;
                    $display("FAIL dma_write_data: got %h, expected %h", bif.bus_dout, e);
                end
            end
        end
        wr_prev = now;
    endtask

    task automatic test_reset();
        repeat (3) step();
        vectors++; if (bif.cpu_enable !== 1'b0) begin miscompares++; $display("FAIL reset_enable: got %b, expected 0", bif.cpu_enable); end
        vectors++; if (bif.dma_active !== 1'b0) begin miscompares++; $display("FAIL reset_dma_active: got %b, expected 0", bif.dma_active); end
        vectors++; if ({bif.cpu_nmi_n, bif.cpu_irq_n} !== 2'b11) begin miscompares++; $display("FAIL reset_int_pins: got %b, expected 11", {bif.cpu_nmi_n, bif.cpu_irq_n}); end
        vectors++; if ({bif.bus_addr, bif.bus_rw_n, bif.bus_dout} !== {16'h1234, 1'b1, 8'h5A}) begin
            miscompares++; $display("FAIL reset_bus_follow: got %h/%b/%h, expected 1234/1/5a", bif.bus_addr, bif.bus_rw_n, bif.bus_dout);
        end
        RESET = 1'b0;
    endtask

    task automatic test_tick();
        int last = 0, n = 0, bad = 0, guard = 0;
        while (n < 6 && guard < 200) begin
            step(); guard++;
            if (bif.cpu_nmi_n !== 1'b1 || bif.cpu_irq_n !== 1'b1) bad++;
            if (bif.cpu_enable === 1'b1) begin
                vectors++;
                if (n == 0 && clk_cnt != CLK_DIV - 1) begin
                    miscompares++; $display("FAIL first_tick: got clk %0d, expected %0d", clk_cnt, CLK_DIV - 1);
                end else if (n > 0 && clk_cnt - last != CLK_DIV) begin
                    miscompares++; $display("FAIL tick_period: got %0d, expected %0d", clk_cnt - last, CLK_DIV);
                end
                last = clk_cnt; n++;
            end
        end
        vectors++; if (n != 6) begin miscompares++; $display("FAIL tick_timeout: got %0d pulses, expected 6", n); end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL idle_int_pins: got %0d bad samples, expected 0", bad); end
    endtask

    task automatic test_idle_bus();
        bif.cpu_addr = 16'h0203; bif.cpu_rw_n = 1'b1; #1;
        vectors++; if (bif.cpu_din !== mem[16'h0203]) begin miscompares++; $display("FAIL read_path: got %h, expected %h", bif.cpu_din, mem[16'h0203]); end
        bif.cpu_addr = 16'h0300; bif.cpu_dout = 8'hC3; bif.cpu_rw_n = 1'b0; #1;
        vectors++; if (bif.cpu_din !== 8'hC3) begin miscompares++; $display("FAIL write_loopback: got %h, expected c3", bif.cpu_din); end
        vectors++; if ({bif.bus_addr, bif.bus_rw_n, bif.bus_dout} !== {16'h0300, 1'b0, 8'hC3}) begin
            miscompares++; $display("FAIL write_bus: got %h/%b/%h, expected 0300/0/c3", bif.bus_addr, bif.bus_rw_n, bif.bus_dout);
        end
        bif.cpu_addr = 16'h8000; bif.cpu_rw_n = 1'b1;
        step();
    endtask

    task automatic test_irq();
        int n = 0;
        bif.irq_mask = 2'b01; bif.irq_src = 2'b01;
        repeat (5) step();
        vectors++; if (bif.cpu_irq_n !== 1'b1) begin miscompares++; $display("FAIL irq_masked: got %b, expected 1", bif.cpu_irq_n); end
        bif.irq_mask = 2'b00;
        do begin step(); n++; end while (bif.cpu_irq_n !== 1'b0 && n < 10);
        vectors++; if (bif.cpu_irq_n !== 1'b0 || n > 3) begin miscompares++; $display("FAIL irq_unmask: got %b after %0d clk, expected 0 within 3", bif.cpu_irq_n, n); end
        bif.irq_src = 2'b00; step(); step();
        vectors++; if (bif.cpu_irq_n !== 1'b0) begin miscompares++; $display("FAIL irq_release_early: got %b, expected 0", bif.cpu_irq_n); end
        step();
        vectors++; if (bif.cpu_irq_n !== 1'b1) begin miscompares++; $display("FAIL irq_release: got %b, expected 1", bif.cpu_irq_n); end
        bif.irq_mask = 2'b01; bif.irq_src = 2'b10; repeat (3) step();
        vectors++; if (bif.cpu_irq_n !== 1'b0) begin miscompares++; $display("FAIL irq_ch1: got %b, expected 0", bif.cpu_irq_n); end
        bif.irq_src = 2'b00; bif.irq_mask = 2'b00; repeat (4) step();
        vectors++; if (bif.cpu_irq_n !== 1'b1) begin miscompares++; $display("FAIL irq_idle: got %b, expected 1", bif.cpu_irq_n); end
    endtask

    // Wait for a tick whose cycle parity is trig_par, then issue the $4014 write in it.
    task automatic trigger_dma(input int trig_par, output int base);
        int guard = 0;
        do begin step(); guard++; end
        while (!(bif.cpu_enable === 1'b1 && (clk_cnt / CLK_DIV) % 2 == trig_par) && guard < 100);
        bif.cpu_addr = 16'h4014; bif.cpu_dout = 8'h02; bif.cpu_rw_n = 1'b0; #1;
        vectors++; if ({bif.bus_addr, bif.bus_rw_n, bif.bus_dout} !== {16'h4014, 1'b0, 8'h02}) begin
            miscompares++; $display("FAIL trigger_write_bus: got %h/%b/%h, expected 4014/0/02", bif.bus_addr, bif.bus_rw_n, bif.bus_dout);
        end
        for (int i = 0; i < DMA_LEN; i++) exp_q.push_back(mem[16'h0200 + 16'(i)]);
        base = wr_cnt;
        step();
        bif.cpu_addr = 16'h8000; bif.cpu_rw_n = 1'b1; #1;
        vectors++; if ({bif.dma_active, bif.cpu_enable} !== 2'b10) begin miscompares++; $display("FAIL dma_start: got active/enable %b, expected 10", {bif.dma_active, bif.cpu_enable}); end
        vectors++; if (bif.cpu_din !== 8'h02) begin miscompares++; $display("FAIL din_hold_start: got %h, expected 02", bif.cpu_din); end
    endtask

    task automatic test_dma(input bit halt_odd, input int nmi_at);
        int base, act = 1, guard = 0, en_cnt = 0, nmi_low = 0, din_bad = 0, first_par = -1;
        int n = 0, low_clk = 0, low_en = 0, exp_cycles;
        exp_cycles = CLK_DIV * (halt_odd ? 2 * DMA_LEN + 1 : 2 * DMA_LEN + 2);
        trigger_dma(halt_odd ? 0 : 1, base);
        while (bif.dma_active === 1'b1 && guard < 8000) begin
            step(); guard++;
            if (bif.dma_active === 1'b1) begin
                act++;
                if (bif.cpu_enable === 1'b1) en_cnt++;
                if (bif.cpu_nmi_n !== 1'b1) nmi_low++;
                if (bif.cpu_din !== 8'h02) din_bad++;
                if (first_par < 0 && bif.bus_rw_n && bif.bus_addr == 16'h0200) first_par = (clk_cnt / CLK_DIV) % 2;
            end
            if (nmi_at >= 0 && wr_cnt - base == nmi_at) bif.nmi_src = 1'b1;
        end
        bif.nmi_src = 1'b0;
        vectors++; if (act != exp_cycles) begin miscompares++; $display("FAIL dma_duration: got %0d clk, expected %0d", act, exp_cycles); end
        vectors++; if (en_cnt != 0) begin miscompares++; $display("FAIL dma_enable_gated: got %0d pulses, expected 0", en_cnt); end
        vectors++; if (wr_cnt - base != DMA_LEN || exp_q.size() != 0) begin
            miscompares++; $display("FAIL dma_write_count: got %0d writes (%0d left), expected %0d", wr_cnt - base, exp_q.size(), DMA_LEN);
        end
        vectors++; if (first_par != 0) begin miscompares++; $display("FAIL first_read_parity: got %0d, expected 0", first_par); end
        vectors++; if (din_bad != 0) begin miscompares++; $display("FAIL din_hold: got %0d bad samples, expected 0", din_bad); end
        vectors++; if (nmi_low != 0) begin miscompares++; $display("FAIL nmi_during_dma: got %0d low samples, expected 0", nmi_low); end
        while (bif.cpu_enable !== 1'b1 && n < 20) begin step(); n++; end
        vectors++; if (n != CLK_DIV - 1) begin miscompares++; $display("FAIL enable_resume: got %0d clk, expected %0d", n, CLK_DIV - 1); end
        vectors++; if (bif.cpu_nmi_n !== 1'b1) begin miscompares++; $display("FAIL nmi_resume_edge: got %b, expected 1", bif.cpu_nmi_n); end
        repeat (5 * CLK_DIV) begin
            step();
            if (bif.cpu_nmi_n === 1'b0) begin
                low_clk++;
                if (bif.cpu_enable === 1'b1) low_en++;
            end
        end
        vectors++; if (low_en != (nmi_at >= 0 ? 2 : 0)) begin miscompares++; $display("FAIL nmi_pulse_enables: got %0d, expected %0d", low_en, nmi_at >= 0 ? 2 : 0); end
        vectors++; if (low_clk != (nmi_at >= 0 ? 2 * CLK_DIV : 0)) begin miscompares++; $display("FAIL nmi_pulse_width: got %0d clk, expected %0d", low_clk, nmi_at >= 0 ? 2 * CLK_DIV : 0); end
    endtask

    task automatic test_reset_mid_dma();
        int base, guard = 0, act_bad = 0, wr_after;
        trigger_dma(0, base);
        while (wr_cnt - base < 100 && guard < 4000) begin step(); guard++; end
        vectors++; if (wr_cnt - base != 100) begin miscompares++; $display("FAIL reset_dma_reach: got %0d writes, expected 100", wr_cnt - base); end
        RESET = 1'b1; #1;
        vectors++; if ({bif.dma_active, bif.cpu_enable, bif.bus_rw_n} !== 3'b001) begin
            miscompares++; $display("FAIL reset_abort: got active/enable/rw_n %b, expected 001", {bif.dma_active, bif.cpu_enable, bif.bus_rw_n});
        end
        exp_q.delete();
        repeat (4) step();
        RESET = 1'b0;
        wr_after = wr_cnt;
        repeat (400) begin
            step();
            if (bif.dma_active !== 1'b0) act_bad++;
        end
        vectors++; if (wr_cnt != wr_after) begin miscompares++; $display("FAIL reset_no_write: got %0d writes, expected 0", wr_cnt - wr_after); end
        vectors++; if (act_bad != 0) begin miscompares++; $display("FAIL reset_stay_idle: got %0d active samples, expected 0", act_bad); end
    endtask

    initial begin
        bif.cpu_addr = 16'h1234; bif.cpu_dout = 8'h5A; bif.cpu_rw_n = 1'b1;
        bif.nmi_src = 1'b0; bif.irq_src = 2'b00; bif.irq_mask = 2'b00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i ^ (i >> 8) ^ 8'hA5);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i * 37 + 11);
        test_reset();
        test_tick();
        test_idle_bus();
        test_irq();
        test_dma(1'b1, -1);
        test_dma(1'b0, -1);
        test_dma(1'b1, 60);
        test_reset_mid_dma();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cpu_bus_ctrl.md
# cpu_bus_ctrl

CPU-side bus controller between the T65 core and the NES memory map; it replaces the fixed glue around the core. It generates the CPU clock enable from the system clock and runs the 2A03 OAM DMA engine ($4014 → $2004). While DMA runs it halts the core and owns the bus. It also conditions NMI and IRQ sources into the core's interrupt pins and implements the write-data loopback onto the core's DI.

## Interface
- CLK_DIV, 12: system clocks per CPU cycle; must be ≥2.
- IRQ_CH, 2: number of level IRQ sources.
- DMA_LEN, 256: bytes per OAM DMA; power of two, ≤256.
- DMA_PAGE_ADDR, 16'h4014: DMA trigger register.
- OAM_DATA_ADDR, 16'h2004: DMA write target.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- cpu_addr  in  16  core address
- cpu_dout  in  8  core write data
- cpu_rw_n  in  1  core read/write_n
- cpu_din  out  8  core read data (DI)
- cpu_enable  out  1  core clock enable, one CLK wide
- cpu_nmi_n  out  1  to core NMI_n
- cpu_irq_n  out  1  to core IRQ_n
- bus_addr  out  16  system bus address
- bus_dout  out  8  system bus write data
- bus_rw_n  out  1  system bus read/write_n
- bus_din  in  8  system bus read data
- nmi_src  in  1  PPU NMI request, active high, asynchronous
- irq_src  in  IRQ_CH  IRQ requests, active high, asynchronous
- irq_mask  in  IRQ_CH  1 = source masked
- dma_active  out  1  DMA owns bus

## Operation
- Tick counter: counts 0..CLK_DIV-1 and wraps. `tick` is asserted when the count equals CLK_DIV-1. Each tick is one CPU cycle, and all CPU-cycle state advances only on tick.
- cpu_enable = tick AND NOT dma_active.
- parity: toggles on every tick; 0 is even.
- Idle bus path (combinational):
  - bus_addr, bus_dout and bus_rw_n follow cpu_*.
  - cpu_din = cpu_dout when cpu_rw_n=0, else bus_din.
- DMA trigger: on a tick with cpu_rw_n=0 and cpu_addr=DMA_PAGE_ADDR:
  - latch page=cpu_dout and go to HALT;
  - the triggering write still reaches the bus.
- DMA FSM (advances on tick only):
  - IDLE → HALT on trigger.
  - HALT → ALIGN if parity=0 during HALT; otherwise HALT → READ.
  - ALIGN → READ.
  - READ: bus_addr={page,idx}, bus_rw_n=1; capture bus_din into data on tick; → WRITE.
  - WRITE: bus_addr=OAM_DATA_ADDR, bus_rw_n=0, bus_dout=data; idx++; → IDLE if idx=DMA_LEN-1, else → READ.
  - In HALT and ALIGN: bus_rw_n=1, bus_addr=cpu_addr.
- dma_active = 1 in all states except IDLE. cpu_din holds its last value while dma_active.
- Total DMA cost: 1+2·DMA_LEN CPU cycles when HALT is odd (513 at default), 2+2·DMA_LEN when HALT is even (514).
- NMI:
  - nmi_src passes through a 2-flop synchronizer; a rising edge sets nmi_pend.
  - On the first cpu_enable pulse with nmi_pend=1, drive cpu_nmi_n low for exactly 2 cpu_enable pulses, then high, and clear nmi_pend.
  - An edge during DMA stays pending until DMA ends.
  - A further edge while cpu_nmi_n is low re-sets nmi_pend, so one more pulse follows.
- IRQ: cpu_irq_n = NOT OR(sync(irq_src) AND NOT irq_mask), level-sensitive and registered on CLK.

## Timing
- Reset values:
  - tick counter 0, parity 0, state IDLE, idx 0, page 0, data 0, nmi_pend 0;
  - cpu_enable 0, dma_active 0, cpu_nmi_n 1, cpu_irq_n 1;
  - bus_* follow cpu_*.
- Reset mid-DMA aborts immediately to IDLE; no further bus writes.
- First tick after reset release occurs CLK_DIV CLK cycles later.
- DMA states change on the CLK edge where tick=1. dma_active rises on the same edge that latches the trigger, so the next tick is gated.
- cpu_enable resumes on the first tick after WRITE of the last byte.
- Interrupt latency: source to synchronized level is 2 CLK; IRQ pin +1 CLK.
- Trigger and NMI edge on the same tick: both are accepted, and the NMI is deferred until after DMA.

## Structure
- Package cpu_bus_pkg:
  - dma_state_t enum {IDLE, HALT, ALIGN, READ, WRITE};
  - default address constants DMA_PAGE_ADDR and OAM_DATA_ADDR.
- Sub-module oam_dma_engine (FSM, page/idx/data registers, DMA bus drive). Tick counter, interrupt conditioning and bus mux stay in the top.
- The T65 core is instantiated outside this block, by the CPU top.

## Test plan
- Reset then free run, CLK_DIV=12 → cpu_enable pulses every 12 CLK; cpu_nmi_n=1 and cpu_irq_n=1 throughout.
- Write $02 to $4014 on an odd HALT → 513 DMA cycles; 256 writes to $2004 with data equal to memory $0200..$02FF in order; no cpu_enable pulses meanwhile.
- Same with HALT on an even cycle → 514 cycles; first READ falls on an even cycle.
- nmi_src rising edge mid-DMA → cpu_nmi_n stays 1 until DMA ends, then is low for exactly 2 cpu_enable pulses.
- irq_src=2'b01 with irq_mask=2'b01 → cpu_irq_n=1; clearing the mask → cpu_irq_n=0 within 3 CLK.
- RESET asserted at byte 100 of a DMA → dma_active=0 asynchronously; no $2004 write after release.
